// File: rtl/keypad_scanner_avalon.sv
// Matrix keypad scanner with debounce, key-event FIFO and Avalon-MM register port.
// Codes are c*ROWS + r; 8'hFF is reserved to mean "no key".
module keypad_scanner_avalon #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 25000,
   parameter int DEBOUNCE   = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic            clk_50,
   input  logic            reset_n,
   input  logic [1:0]      address,
   input  logic            read,
   input  logic            write,
   input  logic [31:0]     writedata,
   output logic [31:0]     readdata,
   output logic            waitrequest,
   input  logic [ROWS-1:0] row,
   output logic [COLS-1:0] column,
   output logic            irq
);

   localparam int STEP_W = $clog2(SCAN_DIV);
   localparam int COL_W  = $clog2(COLS);
   localparam int DEB_W  = $clog2(DEBOUNCE + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam logic [7:0] NO_KEY = 8'hFF;

   typedef enum logic {
      BUS_IDLE,
      BUS_RESP
   } bus_state_t;

   bus_state_t        state, state_next;
   logic              bus_start;
   logic              op_pop, op_ctrl;
   logic [3:0]        op_wdata;
   logic              do_pop, ctrl_wr, flush, clr_ovf;
   logic [31:0]       rd_mux, status_word;

   logic              scan_en, irq_en;
   logic              scan_live, scan_run;
   logic [STEP_W-1:0] step_cnt;
   logic [COL_W-1:0]  col_idx;
   logic              step_last, col_last, frame_done;
   logic [ROWS-1:0]   row_meta, row_sync;
   logic              row_hit;
   logic [7:0]        row_low, col_base, col_code, frame_code;
   logic [7:0]        acc_code, cand_code, stable_code, stable_next;
   logic [DEB_W-1:0]  match_cnt, new_cnt;
   logic              key_push, push_ok;

   logic [7:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty, fifo_full, overflow;

   wire               unused_wdata = ^writedata[31:4];

   // Scanning only runs from the first cycle after reset and while enabled.
   assign scan_run   = scan_en & scan_live;
   assign step_last  = (step_cnt == STEP_W'(SCAN_DIV - 1));
   assign col_last   = (col_idx == COL_W'(COLS - 1));
   assign frame_done = scan_run & step_last & col_last;

   // Drive the active column low, everything else high.
   always_comb begin
      column = '1;
      if (scan_run) begin
         column[col_idx] = 1'b0;
      end
   end

   // Two-flop synchroniser for the asynchronous row inputs.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         row_meta <= '1;
         row_sync <= '1;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
      end
   end

   // Lowest low row in the synchronised sample.
   always_comb begin
      row_hit = 1'b0;
      row_low = 8'd0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (!row_sync[r]) begin
            row_hit = 1'b1;
            row_low = 8'(r);
         end
      end
   end

   assign col_base = 8'(col_idx) * 8'(ROWS);
   assign col_code = row_hit ? (col_base + row_low) : NO_KEY;

   // Columns are visited in ascending order, so the first hit in a frame is the lowest code.
   always_comb begin
      frame_code = acc_code;
      if ((col_idx == '0) || (acc_code == NO_KEY)) begin
         frame_code = col_code;
      end
   end

   // Debounce: count consecutive identical frames, saturating at DEBOUNCE.
   always_comb begin
      new_cnt = DEB_W'(1);
      if (frame_code == cand_code) begin
         new_cnt = (match_cnt == DEB_W'(DEBOUNCE)) ? match_cnt : match_cnt + DEB_W'(1);
      end
      stable_next = (new_cnt == DEB_W'(DEBOUNCE)) ? frame_code : stable_code;
   end

   assign key_push = frame_done & (stable_next != stable_code) & (stable_next != NO_KEY);

   // Step/column counters, frame accumulator and debounce state.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         scan_live   <= 1'b0;
         step_cnt    <= '0;
         col_idx     <= '0;
         acc_code    <= NO_KEY;
         cand_code   <= NO_KEY;
         match_cnt   <= '0;
         stable_code <= NO_KEY;
      end else begin
         scan_live <= 1'b1;
         if (!scan_run) begin
            step_cnt    <= '0;
            col_idx     <= '0;
            acc_code    <= NO_KEY;
            cand_code   <= NO_KEY;
            match_cnt   <= '0;
            stable_code <= NO_KEY;
         end else if (step_last) begin
            step_cnt <= '0;
            col_idx  <= col_last ? '0 : col_idx + COL_W'(1);
            acc_code <= frame_code;
            if (col_last) begin
               cand_code   <= frame_code;
               match_cnt   <= new_cnt;
               stable_code <= stable_next;
            end
         end else begin
            step_cnt <= step_cnt + STEP_W'(1);
         end
      end
   end

   // Bus FSM state register.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state <= BUS_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Bus FSM next state; waitrequest stalls only the first cycle of a transfer.
   always_comb begin
      state_next  = state;
      waitrequest = 1'b0;
      bus_start   = 1'b0;
      case (state)
         BUS_IDLE: begin
            waitrequest = read | write;
            if (read | write) begin
               state_next = BUS_RESP;
               bus_start  = 1'b1;
            end
         end
         BUS_RESP: state_next = BUS_IDLE;
         default:  state_next = BUS_IDLE;
      endcase
   end

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));

   // STATUS register layout.
   always_comb begin
      status_word              = '0;
      status_word[CNT_W-1:0]   = fifo_count;
      status_word[8]           = fifo_empty;
      status_word[9]           = fifo_full;
      status_word[10]          = overflow;
   end

   // Read data selection, evaluated in the stall cycle.
   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0:    rd_mux = fifo_empty ? 32'h0000_00FF : {1'b1, 23'b0, fifo_mem[rd_ptr]};
         2'd1:    rd_mux = status_word;
         2'd2:    rd_mux = {30'b0, irq_en, scan_en};
         default: rd_mux = {24'b0, stable_code};
      endcase
   end

   // Latch the transfer in the stall cycle; its side effects land at the end of RESP.
   // The pop decision is frozen here so a push during the stall cannot be lost.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
         op_pop   <= 1'b0;
         op_ctrl  <= 1'b0;
         op_wdata <= '0;
      end else if (bus_start) begin
         op_pop   <= read && (address == 2'd0) && !fifo_empty;
         op_ctrl  <= !read && write && (address == 2'd2);
         op_wdata <= writedata[3:0];
         if (read) begin
            readdata <= rd_mux;
         end
      end else begin
         op_pop  <= 1'b0;
         op_ctrl <= 1'b0;
      end
   end

   assign do_pop  = (state == BUS_RESP) & op_pop;
   assign ctrl_wr = (state == BUS_RESP) & op_ctrl;
   assign flush   = ctrl_wr & op_wdata[2];
   assign clr_ovf = ctrl_wr & op_wdata[3];
   assign push_ok = key_push & ~fifo_full & ~flush;

   // CONTROL register; flush and overflow-clear are pulses, not stored.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         scan_en <= 1'b1;
         irq_en  <= 1'b0;
      end else if (ctrl_wr) begin
         scan_en <= op_wdata[0];
         irq_en  <= op_wdata[1];
      end
   end

   // FIFO storage.
   always_ff @(posedge clk_50) begin
      if (push_ok) begin
         fifo_mem[wr_ptr] <= frame_code;
      end
   end

   // FIFO pointers, occupancy and sticky overflow; flush beats a simultaneous push.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
         end else begin
            if (push_ok) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, do_pop})
               2'b10:   fifo_count <= fifo_count + CNT_W'(1);
               2'b01:   fifo_count <= fifo_count - CNT_W'(1);
               default: fifo_count <= fifo_count;
            endcase
         end
         if (key_push && fifo_full && !flush) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

   // Level interrupt while enabled and events are pending.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         irq <= 1'b0;
      end else begin
         irq <= irq_en & ~fifo_empty;
      end
   end

endmodule

// File: doc/keypad_scanner_avalon.md
# keypad_scanner_avalon

Parametrised matrix-keypad scanner with an Avalon-MM slave port, debouncing, and a key-event FIFO. It replaces the single-shot pinpad read path: the block scans an ROWS x COLS keypad continuously, queues each debounced key press, and lets the Nios software drain the queue through a small register map. An optional interrupt fires while the queue holds events.

## Interface
Parameters:
- ROWS, default 4, number of keypad row inputs (2..16).
- COLS, default 4, number of keypad column outputs (2..16); ROWS*COLS <= 255.
- SCAN_DIV, default 25000, clk_50 cycles each column is driven (>= 2).
- DEBOUNCE, default 4, consecutive identical frames required to accept a change (>= 1).
- FIFO_DEPTH, default 8, key FIFO entries; power of two, 2..128.

Ports:
- clk_50, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- address, in, 2, register select.
- read, in, 1, Avalon read strobe.
- write, in, 1, Avalon write strobe.
- writedata, in, 32, write data.
- readdata, out, 32, read data.
- waitrequest, out, 1, Avalon stall.
- row, in, ROWS, keypad rows; active-low, externally pulled up.
- column, out, COLS, keypad columns; active-low, one-hot-zero while scanning.
- irq, out, 1, level interrupt.

## Operation
- Register map:
  - 0 DATA (read only). Pops the FIFO. Returns {1'b1, 23'b0, code[7:0]} when the FIFO is non-empty. Returns 0x000000FF when empty, with no pop.
  - 1 STATUS (read only). [7:0] count, [8] empty, [9] full, [10] overflow (sticky).
  - 2 CONTROL (read/write). [0] scan_en, [1] irq_en; reset value 0x1. Write bit 2 = 1 flushes the FIFO. Write bit 3 = 1 clears overflow. Bits 2 and 3 are self-clearing and read as 0.
  - 3 KEYSTATE (read only). The current debounced key code, or 0xFF for no key.
- Writes to addresses 0, 1 and 3 are ignored.
- Key code = c*ROWS + r, where c is the column index and r is the row index.
- Bus FSM has two states:
  - IDLE: waitrequest = read|write (combinational). Any read or write moves the FSM to RESP.
  - RESP: waitrequest = 0 and readdata holds the registered value. The pop, or the CONTROL write effect, happens at the end of this cycle. The FSM then returns to IDLE.
  - If read and write are asserted together, the read wins.
- Scan engine:
  - A column counter steps 0..COLS-1 and wraps. Each step lasts SCAN_DIV cycles.
  - column[c] = 0 for the active column; all other columns are 1.
  - row is sampled in the last cycle of each step, through a 2-flop synchroniser.
  - One frame = COLS steps. The frame result is the lowest code with a low row bit, or NONE.
- Debounce: a candidate result becomes the stable key after it matches for DEBOUNCE consecutive frames. A differing frame restarts the match count.
- Event generation when the stable key changes:
  - NONE→K, or K1→K2: push the new code.
  - K→NONE: no push.
  - Holding a key does not auto-repeat.
- FIFO behaviour:
  - Push while full: the event is dropped and overflow is set.
  - Push and pop in the same cycle: both happen and the count is unchanged.
  - Flush empties the FIFO. Overflow is unchanged.
  - Flush in the same cycle as a push: flush wins.
- scan_en = 0:
  - column is driven to all 1s.
  - The step, frame and debounce state reset, and the stable key becomes NONE.
  - FIFO contents are kept.
- irq = irq_en & ~empty, registered.

## Timing
- Reset values:
  - column all 1s.
  - readdata 0, waitrequest 0 (combinational from strobes), irq 0.
  - FIFO empty, overflow 0, stable key NONE, CONTROL 0x1, bus FSM IDLE.
- Scanning starts in the first cycle after reset_n deasserts: column[0] = 0.
- Each transfer takes 2 cycles: waitrequest is 1 in the strobe's first cycle and 0 in the second. The master holds its strobe until waitrequest = 0.
- Press-to-FIFO latency: at most (DEBOUNCE+1)*COLS*SCAN_DIV + 3 cycles.
- STATUS and irq update 1 cycle after a push, pop or flush.
- reset_n asserted mid-transfer: outputs go to reset values immediately and the transfer is abandoned.

## Test plan
Run with ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4.
- Reset and idle: after reset, STATUS reads 0x100, DATA reads 0xFF, CONTROL reads 0x1, and column cycles 1110→1101→1011→0111, changing every 4 cycles.
- Single press: hold key row 2 / col 1 for 5 frames, then release. The FIFO gets exactly one entry, and DATA reads 0x80000006, then 0xFF.
- Bounce: toggle row 0 / col 0 every frame for 6 frames, then hold it. Nothing is pushed during toggling, and exactly one 0x00 entry is pushed after 2 stable frames.
- Multi-key and change: hold codes 5 and 9 together. Code 5 is pushed. Release 5 while holding 9: 9 is pushed.
- Overflow and flush: create 5 presses with none read. STATUS reads 0x604. Write CONTROL = 0x5: STATUS reads 0x500. Write CONTROL = 0x9: STATUS reads 0x100.
- irq and mid-operation reset: set irq_en and press a key. irq rises 1 cycle after the push and falls after the pop. Asserting reset_n during a read RESP cycle returns all outputs to their reset values.
